// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the tenths-resolution BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    LAP    = 2'd3
  } state_t;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned UNITS_MAX = 9;

endpackage

// File: rtl/bcd_stopwatch_if.sv
// Control pulses, tick level and display outputs of the stopwatch.
interface bcd_stopwatch_if;
  logic        tick;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [15:0] bcd_out;
  logic        running;
  logic        lap_active;
  logic        wrapped;

  modport master (
    output tick, start_stop, clear, lap,
    input  bcd_out, running, lap_active, wrapped
  );

  modport slave (
    input  tick, start_stop, clear, lap,
    output bcd_out, running, lap_active, wrapped
  );
endinterface

// File: rtl/bcd_stopwatch_digit.sv
// One BCD counter digit; wraps to 0 past MAX, carry-out signalled via at_max.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = UNITS_MAX
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [DIGIT_W-1:0] value,
  output logic               at_max
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX);

  assign at_max = (value == MAX_V);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      value <= '0;
    else if (clear_i)
      value <= '0;
    else if (inc_i)
      value <= at_max ? '0 : value + DIGIT_W'(1);
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// M:SS.t stopwatch: run/pause/lap FSM, tick edge detect, cascaded BCD count.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_MAX      = 9,
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic              clock,
  input  logic              reset,
  bcd_stopwatch_if.slave    sw
);

  state_t state, state_next;

  logic               tick_q;
  logic               step;
  logic               clear_count;
  logic               wrap_now;
  logic [15:0]        count;
  logic [15:0]        frozen;
  logic               wrapped_q;
  logic [DIGIT_W-1:0] tenths, sec_units, sec_tens, minutes;
  logic               max_tenths, max_units, max_tens, max_min;

  // Step uses the pre-transition state, so the entering start_stop edge never counts.
  assign step        = sw.tick & ~tick_q & ((state == RUN) || (state == LAP));
  assign clear_count = sw.clear & ((state == IDLE) || (state == PAUSED));
  assign wrap_now    = step & max_tenths & max_units & max_tens & max_min;
  assign count       = {minutes, sec_tens, sec_units, tenths};

  bcd_digit #(.MAX(UNITS_MAX)) u_tenths (
    .clock   (clock),
    .reset   (reset),
    .clear_i (clear_count),
    .inc_i   (step),
    .value   (tenths),
    .at_max  (max_tenths)
  );

  bcd_digit #(.MAX(UNITS_MAX)) u_sec_units (
    .clock   (clock),
    .reset   (reset),
    .clear_i (clear_count),
    .inc_i   (step & max_tenths),
    .value   (sec_units),
    .at_max  (max_units)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clock   (clock),
    .reset   (reset),
    .clear_i (clear_count),
    .inc_i   (step & max_tenths & max_units),
    .value   (sec_tens),
    .at_max  (max_tens)
  );

  bcd_digit #(.MAX(MIN_MAX)) u_minutes (
    .clock   (clock),
    .reset   (reset),
    .clear_i (clear_count),
    .inc_i   (step & max_tenths & max_units & max_tens),
    .value   (minutes),
    .at_max  (max_min)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (sw.clear)           state_next = IDLE;
        else if (sw.start_stop) state_next = RUN;
      end
      RUN: begin
        if (sw.start_stop)      state_next = PAUSED;
        else if (sw.lap)        state_next = LAP;
      end
      LAP: begin
        if (sw.start_stop)      state_next = PAUSED;
        else if (sw.lap)        state_next = RUN;
      end
      PAUSED: begin
        if (sw.clear)           state_next = IDLE;
        else if (sw.start_stop) state_next = RUN;
      end
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    sw.running    = (state == RUN) || (state == LAP);
    sw.lap_active = (state == LAP);
    sw.bcd_out    = (state == LAP) ? frozen : count;
    sw.wrapped    = wrapped_q;
  end

  // Frozen value captures the pre-step count on the edge that enters LAP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_q    <= 1'b0;
      frozen    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      tick_q    <= sw.tick;
      wrapped_q <= wrap_now;
      if ((state == RUN) && sw.lap && !sw.start_stop)
        frozen <= count;
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch with a tenths-count model and expected-value queue.
module tb_bcd_stopwatch;

  logic clock;
  logic reset;
  int unsigned checks;
  int unsigned failures;

  bcd_stopwatch_if sw ();

  bcd_stopwatch #(.MIN_MAX(9), .SEC_TENS_MAX(5)) dut (
    .clock (clock),
    .reset (reset),
    .sw    (sw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          model;
  bit          counting;
  bit          lap_on;
  logic [15:0] frozen;
  logic [15:0] sb[$];

  function automatic logic [15:0] to_bcd(input int t);
    int m, s;
    m = t / 600;
    s = (t % 600) / 10;
    return {4'(m), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
  endfunction

  function automatic logic [15:0] shown();
    return lap_on ? frozen : to_bcd(model);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input bit ss, input bit cl, input bit lp);
    sw.start_stop = ss;
    sw.clear      = cl;
    sw.lap        = lp;
    step_cycle();
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
    sw.lap        = 1'b0;
  endtask

  // One tick rising edge: held high for one clock, then low for one clock.
  task automatic tick_edge();
    logic [15:0] pre;
    bit          wrap;
    pre  = shown();
    wrap = 1'b0;
    if (counting) begin
      if (model == 5999) begin
        model = 0;
        wrap  = 1'b1;
      end else begin
        model++;
      end
    end
    sb.push_back(shown());
    sw.tick = 1'b1;
    #1;
    check("tick_latency", sw.bcd_out, pre);
    step_cycle();
    check("tick_count", sw.bcd_out, sb.pop_front());
    check("wrap_pulse", 16'(sw.wrapped), 16'(wrap));
    sw.tick = 1'b0;
    step_cycle();
    check("wrap_single", 16'(sw.wrapped), 16'h0);
  endtask

  initial begin
    checks = 0; failures = 0;
    model = 0; counting = 1'b0; lap_on = 1'b0; frozen = '0;
    reset = 1'b1;
    sw.tick = 1'b0; sw.start_stop = 1'b0; sw.clear = 1'b0; sw.lap = 1'b0;
    repeat (3) step_cycle();
    check("reset_bcd", sw.bcd_out, 16'h0000);
    check("reset_running", 16'(sw.running), 16'h0);
    check("reset_lap", 16'(sw.lap_active), 16'h0);
    check("reset_wrapped", 16'(sw.wrapped), 16'h0);
    reset = 1'b0;
    step_cycle();

    // Ticks while idle do nothing.
    repeat (5) tick_edge();
    check("idle_running", 16'(sw.running), 16'h0);

    pulse(1'b1, 1'b0, 1'b0);
    counting = 1'b1;
    check("run_running", 16'(sw.running), 16'h1);
    repeat (12) tick_edge();
    check("run_0012", sw.bcd_out, 16'h0012);

    while (model != 5999) tick_edge();
    check("pre_wrap", sw.bcd_out, 16'h9599);
    tick_edge();
    check("post_wrap", sw.bcd_out, 16'h0000);
    check("wrap_running", 16'(sw.running), 16'h1);

    while (model != 34) tick_edge();
    pulse(1'b0, 1'b0, 1'b1);
    lap_on = 1'b1;
    frozen = to_bcd(34);
    check("lap_enter", sw.bcd_out, 16'h0034);
    check("lap_active", 16'(sw.lap_active), 16'h1);
    repeat (7) tick_edge();
    check("lap_hold", sw.bcd_out, 16'h0034);
    pulse(1'b0, 1'b0, 1'b1);
    lap_on = 1'b0;
    check("lap_release", sw.bcd_out, 16'h0041);
    check("lap_inactive", 16'(sw.lap_active), 16'h0);

    pulse(1'b0, 1'b1, 1'b0);
    check("clear_in_run", sw.bcd_out, 16'h0041);
    check("clear_run_state", 16'(sw.running), 16'h1);
    pulse(1'b1, 1'b0, 1'b0);
    counting = 1'b0;
    check("pause_running", 16'(sw.running), 16'h0);
    tick_edge();
    pulse(1'b0, 1'b1, 1'b0);
    model = 0;
    check("pause_clear", sw.bcd_out, 16'h0000);
    pulse(1'b1, 1'b0, 1'b0);
    counting = 1'b1;
    while (model != 20) tick_edge();
    pulse(1'b1, 1'b0, 1'b0);
    counting = 1'b0;
    check("pause_0020", sw.bcd_out, 16'h0020);
    pulse(1'b1, 1'b1, 1'b0);
    model = 0;
    check("clear_beats_ss", sw.bcd_out, 16'h0000);
    check("clear_ss_running", 16'(sw.running), 16'h0);
    tick_edge();

    pulse(1'b1, 1'b0, 1'b0);
    counting = 1'b1;
    while (model != 75) tick_edge();
    check("pre_reset", sw.bcd_out, 16'h0075);
    sw.tick = 1'b1;
    reset   = 1'b1;
    #1;
    model = 0; counting = 1'b0; lap_on = 1'b0;
    check("async_reset_bcd", sw.bcd_out, 16'h0000);
    check("async_reset_run", 16'(sw.running), 16'h0);
    step_cycle();
    reset = 1'b0;
    repeat (2) step_cycle();
    check("tick_high_after_reset", sw.bcd_out, 16'h0000);
    sw.tick = 1'b0;
    step_cycle();
    tick_edge();
    pulse(1'b1, 1'b0, 1'b0);
    counting = 1'b1;
    tick_edge();
    check("restart_0001", sw.bcd_out, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
